uart_rx: RTL and testbench

Asynchronous serial receiver that samples a single-wire line, reconstructs frames of one start bit, DATA_WIDTH data bits (LSB first), optional parity bit and STOP_BITS stop bits, and presents each received word with a one-cycle valid strobe plus parity and framing error flags. It is the receive-side counterpart of the team's uart_tx, uses the same parameter set and the same bit period of PRESCALER clocks, and must round-trip with it in loopback.

---
 rtl/uart_rx.sv | 199 +++++++++++++++++++
 tb/tb_uart_rx.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx
//  Purpose  : Asynchronous serial receiver. Recovers frames of one start bit,
//             DATA_WIDTH data bits (LSB first), an optional parity bit and
//             STOP_BITS stop bits, and presents each word with a one-cycle
//             valid strobe plus parity and framing error flags.
//  Revision : 1.0  initial release
// ============================================================================
module uart_rx #(
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY     = 1,
    parameter int EVEN       = 1,
    parameter int PRESCALER  = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx,
    output logic [DATA_WIDTH-1:0] rxd,
    output logic                  rxv,
    output logic                  perr,
    output logic                  ferr,
    output logic                  active
);

    localparam int c_HALF = PRESCALER / 2;
    localparam int c_PW   = $clog2(PRESCALER);
    localparam int c_N    = 1 + DATA_WIDTH + PARITY + STOP_BITS;
    localparam int c_BW   = $clog2(c_N + 1);

    localparam logic [c_PW-1:0] c_HALF_V    = c_PW'(c_HALF);
    localparam logic [c_PW-1:0] c_WRAP_V    = c_PW'(PRESCALER - 1);
    localparam logic [c_BW-1:0] c_LAST_DATA = c_BW'(DATA_WIDTH - 1);
    localparam logic [c_BW-1:0] c_LAST_STOP = c_BW'(STOP_BITS - 1);
    // Odd parity expects the XOR of data and parity bit to be 1.
    localparam logic            c_ODD       = (EVEN == 0);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_PAR   = 3'd3,
        S_STOP  = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic                  r_rx_meta;
    logic                  r_rx_s;
    logic                  r_rx_s_d;
    logic [c_PW-1:0]       r_psk_ctr;
    logic [c_BW-1:0]       r_bit_ctr;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_par_acc;
    logic                  r_perr_nxt;
    logic                  r_ferr_nxt;
    logic                  w_edge;
    logic                  w_sample;
    logic                  w_wrap;
    logic                  w_frame_done;

    // Only a high-to-low transition starts a frame, so a stuck-low line
    // cannot retrigger the receiver.
    assign w_edge   = r_rx_s_d & ~r_rx_s;
    assign w_sample = (r_state != S_IDLE) && (r_psk_ctr == c_HALF_V);
    assign w_wrap   = (r_state != S_IDLE) && (r_psk_ctr == c_WRAP_V);
    assign active   = (r_state != S_IDLE);

    // Two-flop synchronizer plus one delay stage for edge detection; idle high.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_s_d  <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
            r_rx_s_d  <= r_rx_s;
        end
    end

    // Frame state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode; the last stop sample returns to idle at once so a
    // back-to-back start edge is caught within half a bit.
    always_comb begin
        w_state_next = r_state;
        w_frame_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_edge) begin
                    w_state_next = S_START;
                end
            end
            S_START: begin
                if (w_sample && r_rx_s) begin
                    w_state_next = S_IDLE;
                end else if (w_wrap) begin
                    w_state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (w_wrap && (r_bit_ctr == c_LAST_DATA)) begin
                    w_state_next = (PARITY != 0) ? S_PAR : S_STOP;
                end
            end
            S_PAR: begin
                if (w_wrap) begin
                    w_state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (w_sample && (r_bit_ctr == c_LAST_STOP)) begin
                    w_state_next = S_IDLE;
                    w_frame_done = 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Bit timing, data capture, error accumulation and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_psk_ctr  <= '0;
            r_bit_ctr  <= '0;
            r_shift    <= '0;
            r_par_acc  <= 1'b0;
            r_perr_nxt <= 1'b0;
            r_ferr_nxt <= 1'b0;
            rxd        <= '0;
            rxv        <= 1'b0;
            perr       <= 1'b0;
            ferr       <= 1'b0;
        end else begin
            rxv <= w_frame_done;

            if (r_state == S_IDLE) begin
                r_psk_ctr <= '0;
            end else if (w_wrap) begin
                r_psk_ctr <= '0;
            end else begin
                r_psk_ctr <= r_psk_ctr + c_PW'(1);
            end

            // Counts bits within the current phase; cleared on every transition.
            if (r_state != w_state_next) begin
                r_bit_ctr <= '0;
            end else if (w_wrap) begin
                r_bit_ctr <= r_bit_ctr + c_BW'(1);
            end

            if ((r_state == S_IDLE) && w_edge) begin
                r_par_acc  <= 1'b0;
                r_perr_nxt <= 1'b0;
                r_ferr_nxt <= 1'b0;
            end

            if (w_sample) begin
                case (r_state)
                    S_DATA: begin
                        r_shift   <= {r_rx_s, r_shift[DATA_WIDTH-1:1]};
                        r_par_acc <= r_par_acc ^ r_rx_s;
                    end
                    S_PAR: begin
                        r_perr_nxt <= r_par_acc ^ r_rx_s ^ c_ODD;
                    end
                    S_STOP: begin
                        if (!r_rx_s) begin
                            r_ferr_nxt <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end

            // The final stop sample is folded in directly since its
            // accumulator update lands in the same edge.
            if (w_frame_done) begin
                rxd  <= r_shift;
                perr <= r_perr_nxt;
                ferr <= r_ferr_nxt | ~r_rx_s;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx
//  Purpose  : Self-checking bench for uart_rx. Three receivers with different
//             frame formats, each on its own line driven by a bit-level
//             transmitter model; expected words are queued per receiver.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_rx;

    localparam int c_PRESC = 15;

    logic       clk;
    logic       rst;
    logic [2:0] rx_l;
    logic [7:0] rxd_w    [3];
    logic       rxv_w    [3];
    logic       perr_w   [3];
    logic       ferr_w   [3];
    logic       active_w [3];

    int n_vec;
    int n_err;
    int cyc;
    int rxv_cnt [3];
    int rxv_cyc [3];

    // Packed expectation: {ferr, perr, data}.
    logic [9:0] exp_q [3][$];

    // Receiver 0: defaults (parity on, even, one stop bit).
    uart_rx u_dut0 (
        .clk(clk), .rst(rst), .rx(rx_l[0]),
        .rxd(rxd_w[0]), .rxv(rxv_w[0]), .perr(perr_w[0]),
        .ferr(ferr_w[0]), .active(active_w[0])
    );

    // Receiver 1: odd parity, two stop bits.
    uart_rx #(.EVEN(0), .STOP_BITS(2)) u_dut1 (
        .clk(clk), .rst(rst), .rx(rx_l[1]),
        .rxd(rxd_w[1]), .rxv(rxv_w[1]), .perr(perr_w[1]),
        .ferr(ferr_w[1]), .active(active_w[1])
    );

    // Receiver 2: no parity bit.
    uart_rx #(.PARITY(0)) u_dut2 (
        .clk(clk), .rst(rst), .rx(rx_l[2]),
        .rxd(rxd_w[2]), .rxv(rxv_w[2]), .perr(perr_w[2]),
        .ferr(ferr_w[2]), .active(active_w[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int cfg_par(input int i);
        return (i == 2) ? 0 : 1;
    endfunction

    function automatic int cfg_even(input int i);
        return (i == 1) ? 0 : 1;
    endfunction

    function automatic int cfg_stop(input int i);
        return (i == 1) ? 2 : 1;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every strobe is matched against the oldest queued frame.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rxv_w[i] === 1'b1) begin
                logic [9:0] e;
                rxv_cnt[i] = rxv_cnt[i] + 1;
                rxv_cyc[i] = cyc;
                if (exp_q[i].size() == 0) begin
                    check($sformatf("rx%0d_unexpected_rxv", i), 32'd1, 32'd0);
                end else begin
                    e = exp_q[i].pop_front();
                    check($sformatf("rx%0d_rxd", i),  {24'd0, rxd_w[i]}, {24'd0, e[7:0]});
                    check($sformatf("rx%0d_perr", i), {31'd0, perr_w[i]}, {31'd0, e[8]});
                    check($sformatf("rx%0d_ferr", i), {31'd0, ferr_w[i]}, {31'd0, e[9]});
                end
            end
        end
    end

    task automatic drive_bit(input int idx, input logic b);
        rx_l[idx] = b;
        repeat (c_PRESC) @(negedge clk);
    endtask

    // pbit < 0 sends the correct parity bit, otherwise pbit[0] is forced.
    task automatic send(input int idx, input logic [7:0] d, input int pbit, input logic stop_v);
        logic good;
        logic pb;
        logic pe;
        good = (cfg_even(idx) != 0) ? ^d : ~^d;
        pb   = (pbit < 0) ? good : pbit[0];
        pe   = (cfg_par(idx) != 0) && (pb != good);
        exp_q[idx].push_back({~stop_v, pe, d});
        drive_bit(idx, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(idx, d[i]);
        if (cfg_par(idx) != 0) drive_bit(idx, pb);
        for (int s = 0; s < cfg_stop(idx); s++) drive_bit(idx, stop_v);
    endtask

    task automatic drain();
        int total;
        total = exp_q[0].size() + exp_q[1].size() + exp_q[2].size();
        for (int k = 0; k < 400 && total != 0; k++) begin
            @(negedge clk);
            total = exp_q[0].size() + exp_q[1].size() + exp_q[2].size();
        end
        check("drain_pending", total, 32'd0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_rxd"},    {24'd0, rxd_w[0]},    32'd0);
        check({tag, "_rxv"},    {31'd0, rxv_w[0]},    32'd0);
        check({tag, "_perr"},   {31'd0, perr_w[0]},   32'd0);
        check({tag, "_ferr"},   {31'd0, ferr_w[0]},   32'd0);
        check({tag, "_active"}, {31'd0, active_w[0]}, 32'd0);
    endtask

    initial begin
        int c0;
        int cnt;
        logic [7:0] v;
        n_vec = 0;
        n_err = 0;
        cyc   = 0;
        for (int i = 0; i < 3; i++) begin
            rxv_cnt[i] = 0;
            rxv_cyc[i] = 0;
        end
        rst  = 1'b1;
        rx_l = 3'b111;
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // Basic frame and latency: START entered 3 cycles after the line
        // falls, rxv at t0 + 10*15 + 7 + 1.
        c0 = cyc;
        send(0, 8'hA5, -1, 1'b1);
        repeat (5) @(negedge clk);
        check("latency_rxv", rxv_cyc[0] - c0, 32'd161);
        drain();

        // Wrong parity bit on even build, same bit is correct on odd build.
        send(0, 8'hA5, 1, 1'b1);
        send(1, 8'hA5, 1, 1'b1);
        send(2, 8'hC3, -1, 1'b1);
        drain();

        // Stop bit low, then line held low: exactly one strobe with ferr.
        cnt = rxv_cnt[0];
        send(0, 8'hA5, -1, 1'b0);
        repeat (40) @(negedge clk);
        check("ferr_one_rxv", rxv_cnt[0] - cnt, 32'd1);
        rx_l[0] = 1'b1;
        repeat (30) @(negedge clk);
        check("ferr_no_retrigger", rxv_cnt[0] - cnt, 32'd1);
        send(0, 8'h81, -1, 1'b1);
        drain();

        // Short glitch: start sample sees high, frame is dropped.
        cnt = rxv_cnt[0];
        rx_l[0] = 1'b0;
        repeat (5) @(negedge clk);
        check("glitch_active_high", {31'd0, active_w[0]}, 32'd1);
        rx_l[0] = 1'b1;
        repeat (20) @(negedge clk);
        check("glitch_active_low", {31'd0, active_w[0]}, 32'd0);
        check("glitch_no_rxv", rxv_cnt[0] - cnt, 32'd0);

        // Reset in the middle of the data bits of 0x3C.
        cnt = rxv_cnt[0];
        v = 8'h3C;
        drive_bit(0, 1'b0);
        for (int i = 0; i < 3; i++) drive_bit(0, v[i]);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_zero_outputs("midreset");
        rx_l[0] = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check("midreset_no_rxv", rxv_cnt[0] - cnt, 32'd0);
        send(0, 8'h5A, -1, 1'b1);
        drain();
        check("midreset_one_rxv", rxv_cnt[0] - cnt, 32'd1);

        // Back-to-back stream of every byte on all three formats.
        fork
            begin
                for (int w = 0; w < 256; w++) send(0, 8'(w), -1, 1'b1);
            end
            begin
                for (int w = 0; w < 256; w++) send(1, 8'(w), -1, 1'b1);
            end
            begin
                for (int w = 0; w < 256; w++) send(2, 8'(w), -1, 1'b1);
            end
        join
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
